// File: rtl/lrp_synd_init.sv
// lrp_synd_init: frame-level front end for a Chase-style BCH decoder.
// Accumulates the hard-decision syndromes S1/S3/S5 over one received frame
// and keeps the three least-reliable positions as {a^5p, a^3p, a^p} triples.
// A start pulse (in any state) restarts the frame; the reset is asynchronous.
module lrp_synd_init #(
  parameter int GF_LEN = 10,
  parameter int CODE_LEN = 1023,
  parameter logic [GF_LEN:0] PRIM_POLY = 11'h409,
  parameter int REL_LEN = 4
) (
  input  logic                  clk,
  input  logic                  in_ctr_Arst,
  input  logic                  in_ctr_start,
  input  logic                  in_valid,
  input  logic                  in_hd_bit,
  input  logic [REL_LEN-1:0]    in_rel,
  output logic                  out_busy,
  output logic                  out_valid,
  output logic [GF_LEN-1:0]     out_hd_synd1,
  output logic [GF_LEN-1:0]     out_hd_synd3,
  output logic [GF_LEN-1:0]     out_hd_synd5,
  output logic [3*GF_LEN-1:0]   out_alpha1,
  output logic [3*GF_LEN-1:0]   out_alpha2,
  output logic [3*GF_LEN-1:0]   out_alpha3
);

  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODE_LEN - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [GF_LEN-1:0] GF_ONE = {{(GF_LEN-1){1'b0}}, 1'b1};
  // One LRP slot: {occupied, rel, a^5p, a^3p, a^p}; an all-zero slot is empty
  // and therefore already drives zeros on its alpha bus.
  localparam int SLOT_W = 1 + REL_LEN + 3 * GF_LEN;

  // Multiply by alpha n times, reducing modulo the primitive polynomial.
  function automatic logic [GF_LEN-1:0] gf_mul_alpha_n(input logic [GF_LEN-1:0] x,
                                                       input int n);
    logic [GF_LEN-1:0] r;
    r = x;
    for (int k = 0; k < n; k++) begin
      if (r[GF_LEN-1]) begin
        r = {r[GF_LEN-2:0], 1'b0} ^ PRIM_POLY[GF_LEN-1:0];
      end else begin
        r = {r[GF_LEN-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  logic [1:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GF_LEN-1:0]    p1_q, p1_d, p3_q, p3_d, p5_q, p5_d;
  logic [GF_LEN-1:0]    s1_q, s1_d, s3_q, s3_d, s5_q, s5_d;
  logic [SLOT_W-1:0]    slot_q [3];
  logic [SLOT_W-1:0]    slot_d [3];
  logic [SLOT_W-1:0]    new_slot_s;
  logic                 accept_s;
  logic [2:0]           lt_s;

  // Next-state logic: restart, sample acceptance, syndrome and LRP update.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    p1_d       = p1_q;
    p3_d       = p3_q;
    p5_d       = p5_q;
    s1_d       = s1_q;
    s3_d       = s3_q;
    s5_d       = s5_q;
    slot_d     = slot_q;
    new_slot_s = {1'b1, in_rel, p5_q, p3_q, p1_q};
    accept_s   = (state_q == S_ACC) && in_valid && !in_ctr_start;
    // Empty slots compare as "greater than any rel"; strict less-than keeps
    // the earlier position ahead on ties.
    for (int i = 0; i < 3; i++) begin
      lt_s[i] = !slot_q[i][SLOT_W-1] || (in_rel < slot_q[i][SLOT_W-2 -: REL_LEN]);
    end

    if (in_ctr_start) begin
      state_d = S_ACC;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      cnt_d   = '0;
      p1_d    = GF_ONE;
      p3_d    = GF_ONE;
      p5_d    = GF_ONE;
      s1_d    = '0;
      s3_d    = '0;
      s5_d    = '0;
      for (int i = 0; i < 3; i++) begin
        slot_d[i] = '0;
      end
    end else if (accept_s) begin
      if (in_hd_bit) begin
        s1_d = s1_q ^ p1_q;
        s3_d = s3_q ^ p3_q;
        s5_d = s5_q ^ p5_q;
      end else begin
        s1_d = s1_q;
        s3_d = s3_q;
        s5_d = s5_q;
      end
      p1_d  = gf_mul_alpha_n(p1_q, 1);
      p3_d  = gf_mul_alpha_n(p3_q, 3);
      p5_d  = gf_mul_alpha_n(p5_q, 5);
      cnt_d = cnt_q + CNT_W'(1);
      if (lt_s[0]) begin
        slot_d[2] = slot_q[1];
        slot_d[1] = slot_q[0];
        slot_d[0] = new_slot_s;
      end else if (lt_s[1]) begin
        slot_d[2] = slot_q[1];
        slot_d[1] = new_slot_s;
      end else if (lt_s[2]) begin
        slot_d[2] = new_slot_s;
      end else begin
        slot_d = slot_q;
      end
      if (cnt_q == LAST_IDX) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end else begin
        state_d = S_ACC;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers; the asynchronous reset discards any frame in progress.
  always_ff @(posedge clk or posedge in_ctr_Arst) begin
    if (in_ctr_Arst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      p1_q    <= '0;
      p3_q    <= '0;
      p5_q    <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      s5_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p3_q    <= p3_d;
      p5_q    <= p5_d;
      s1_q    <= s1_d;
      s3_q    <= s3_d;
      s5_q    <= s5_d;
      for (int i = 0; i < 3; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign out_busy     = busy_q;
  assign out_valid    = valid_q;
  assign out_hd_synd1 = s1_q;
  assign out_hd_synd3 = s3_q;
  assign out_hd_synd5 = s5_q;
  assign out_alpha1   = slot_q[0][3*GF_LEN-1:0];
  assign out_alpha2   = slot_q[1][3*GF_LEN-1:0];
  assign out_alpha3   = slot_q[2][3*GF_LEN-1:0];

endmodule
